// File: rtl/case_conv_stream_ctrl.sv
// Framed byte-stream sequencer for ASCII case conversion (pass/upper/lower/toggle) with an output FIFO.
// Optional converted-byte counter on conv_count when CASE_CONV_STATS_EN is defined.
module case_conv_stream_ctrl #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_start,
  input  logic [1:0]       cfg_mode,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [7:0]       out_data,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
`ifdef CASE_CONV_STATS_EN
  ,
  output logic [CNT_W-1:0] conv_count
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t      state_q;
  logic [1:0]  mode_q;
  logic        done_q;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [8:0]  mem_q [DEPTH];
  logic [8:0]  head;
  logic [7:0]  conv_w;
  logic        fifo_empty, fifo_full, accept, pop;

  function automatic logic [7:0] conv_byte(input logic [1:0] mode, input logic [7:0] b);
    logic is_up, is_lo;
    is_up = (b >= 8'h41) && (b <= 8'h5A);
    is_lo = (b >= 8'h61) && (b <= 8'h7A);
    conv_byte = b;
    case (mode)
      2'b01:   if (is_lo) conv_byte = b & 8'hDF;
      2'b10:   if (is_up) conv_byte = b | 8'h20;
      2'b11:   if (is_up || is_lo) conv_byte = b ^ 8'h20;
      default: conv_byte = b;
    endcase
  endfunction

  // Full/empty come from the extra pointer bit, so in_ready never depends on the same-cycle pop.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign in_ready   = (state_q == RUN) && !fifo_full;
  assign accept     = in_valid && in_ready;
  assign out_valid  = !fifo_empty;
  assign pop        = out_valid && out_ready;
  assign head       = mem_q[rd_ptr_q[AW-1:0]];
  assign out_data   = out_valid ? head[7:0] : 8'h00;
  assign out_last   = out_valid && head[8];
  assign conv_w     = conv_byte(mode_q, in_data);
  assign busy       = (state_q != IDLE);
  assign done       = done_q;

  assign wr_ptr_d = accept ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
  assign rd_ptr_d = pop    ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;

  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q[AW-1:0]] <= {in_last, conv_w};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= 2'b00;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (cfg_start) begin
          mode_q  <= cfg_mode;
          state_q <= RUN;
        end
        RUN:  if (accept && in_last) state_q <= DRAIN;
        DRAIN: if (pop && out_last) begin
          state_q <= IDLE;
          done_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef CASE_CONV_STATS_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE && cfg_start)
      cnt_d = '0;
    else if (accept && (conv_w != in_data) && (cnt_q != '1))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign conv_count = cnt_q;
`endif

endmodule

// File: tb/tb_case_conv_stream_ctrl.sv
// Scoreboard bench for case_conv_stream_ctrl: expected bytes queued on accept, compared on delivery.
module tb_case_conv_stream_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_start = 1'b0;
  logic [1:0]  cfg_mode = 2'b00;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_last;
  logic        out_ready = 1'b1;
  logic        busy;
  logic        done;
`ifdef CASE_CONV_STATS_EN
  logic [15:0] conv_count;
`endif

  int          n_cmp = 0;
  int          n_err = 0;
  logic [8:0]  exp_q[$];
  logic [1:0]  mdl_mode = 2'b00;
  int          exp_cnt = 0;

  case_conv_stream_ctrl #(.DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_mode(cfg_mode),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .busy(busy), .done(done)
`ifdef CASE_CONV_STATS_EN
    , .conv_count(conv_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_conv(input logic [1:0] m, input logic [7:0] b);
    logic up, lo;
    up = (b > 8'h40) && (b < 8'h5B);
    lo = (b > 8'h60) && (b < 8'h7B);
    if (m == 2'b01 && lo) return b - 8'h20;
    if (m == 2'b10 && up) return b + 8'h20;
    if (m == 2'b11 && up) return b + 8'h20;
    if (m == 2'b11 && lo) return b - 8'h20;
    return b;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) begin
        exp_q.push_back({in_last, model_conv(mdl_mode, in_data)});
        if (model_conv(mdl_mode, in_data) != in_data) exp_cnt++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_out", {23'd0, out_last, out_data}, 32'h1FF);
        else chk("out_byte", {23'd0, out_last, out_data}, {23'd0, exp_q.pop_front()});
      end
    end
  end

  // All tasks start and end at posedge+1.
  task automatic start_pkt(input logic [1:0] m);
    cfg_start = 1'b1;
    cfg_mode  = m;
    mdl_mode  = m;
    exp_cnt   = 0;
    @(posedge clk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    logic acc;
    int   guard;
    guard = 0;
    in_valid = 1'b1;
    in_data  = b;
    in_last  = last;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      guard++;
    end while (!acc && guard < 200);
    if (!acc) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done();
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!done && guard < 200);
    chk("done_seen", {31'd0, done}, 1);
    chk("busy_with_done", {31'd0, busy}, 0);
    chk("queue_drained", exp_q.size(), 0);
`ifdef CASE_CONV_STATS_EN
    chk("conv_count", {16'd0, conv_count}, exp_cnt);
`endif
    @(negedge clk);
    chk("done_pulse_1cyc", {31'd0, done}, 0);
    @(posedge clk); #1;
  endtask

  task automatic send_pkt(input logic [1:0] m, input logic [7:0] bytes[$]);
    start_pkt(m);
    foreach (bytes[i]) send(bytes[i], i == bytes.size() - 1);
    wait_done();
  endtask

  initial begin
    logic [7:0] pkt[$];
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 0);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_data", {24'd0, out_data}, 0);
    chk("rst_out_last", {31'd0, out_last}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
`ifdef CASE_CONV_STATS_EN
    chk("rst_conv_count", {16'd0, conv_count}, 0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // 1) upper on "aZ{"
    start_pkt(2'b01);
    @(negedge clk);
    chk("busy_after_start", {31'd0, busy}, 1);
    @(posedge clk); #1;
    send(8'h61, 1'b0);
    send(8'h5A, 1'b0);
    send(8'h7B, 1'b1);
    wait_done();
`ifdef CASE_CONV_STATS_EN
    chk("conv_count_t1", {16'd0, conv_count}, 1);
`endif

    // 2) lower on range edges
    pkt = '{8'h41, 8'h5A, 8'h40, 8'h5B};
    send_pkt(2'b10, pkt);

    // 3) toggle and pass
    pkt = '{8'h41, 8'h62, 8'h31};
    send_pkt(2'b11, pkt);
    pkt = '{8'hE1};
    send_pkt(2'b00, pkt);
    pkt = '{8'h61, 8'h7A, 8'h60, 8'h7B, 8'hC1};
    send_pkt(2'b01, pkt);

    // 4) full FIFO back-pressure
    out_ready = 1'b0;
    start_pkt(2'b01);
    for (int i = 0; i < 4; i++) send(8'h61 + 8'(i), 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h78;
    in_last  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_in_ready", {31'd0, in_ready}, 0);
      chk("stall_valid", {31'd0, out_valid}, 1);
      chk("stall_head", {23'd0, out_last, out_data}, {23'd0, exp_q[0]});
      @(posedge clk); #1;
    end
    chk("held_depth", exp_q.size(), 4);
    out_ready = 1'b1;
    send(8'h78, 1'b1);
    wait_done();

    // 5a) cfg_start during RUN must not change mode
    start_pkt(2'b01);
    send(8'h61, 1'b0);
    cfg_start = 1'b1;
    cfg_mode  = 2'b10;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    send(8'h62, 1'b1);
    wait_done();

    // 5b) reset mid-RUN with bytes queued
    out_ready = 1'b0;
    start_pkt(2'b01);
    send(8'h78, 1'b0);
    send(8'h79, 1'b0);
    @(negedge clk);
    chk("pre_rst_valid", {31'd0, out_valid}, 1);
    chk("pre_rst_busy", {31'd0, busy}, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_out_valid", {31'd0, out_valid}, 0);
    chk("midrst_busy", {31'd0, busy}, 0);
    chk("midrst_in_ready", {31'd0, in_ready}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    pkt = '{8'h51, 8'h7A};
    send_pkt(2'b11, pkt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
